// File: rtl/multimode_demod.sv
// Multimode demodulator: ASK / FSK / BPSK / raw slicer over offset-binary samples.
// Optional DEMOD_MARGIN_CNT_EN adds margin_cnt, a count of near-threshold decisions.
module multimode_demod #(
  parameter int SPB     = 16,
  parameter int CAR_PER = 8,
  parameter int ASK_THR = 256,
  parameter int FSK_THR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic [6:0] sample,
  input  logic       sample_valid,
  input  logic       sync,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy
`ifdef DEMOD_MARGIN_CNT_EN
  ,
  output logic [7:0] margin_cnt
`endif
);

  localparam int CNT_W = $clog2(SPB);
  localparam int ACC_W = 8 + $clog2(SPB);
  localparam int PH_W  = $clog2(CAR_PER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPB - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CAR_PER - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CAR_PER / 2);

  localparam logic [1:0] M_ASK  = 2'b00;
  localparam logic [1:0] M_FSK  = 2'b01;
  localparam logic [1:0] M_BPSK = 2'b10;
  localparam logic [1:0] M_RAW  = 2'b11;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_cur;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_cur, acc_nxt;
  logic [PH_W-1:0]         phase_q, phase_d, phase_cur;
  logic [1:0]              mode_q, mode_d, mode_eff;
  logic                    prev_neg_q, prev_neg_d, prev_cur;
  logic                    bit_q, bit_d;
  logic                    bv_q, bv_d;

  logic signed [7:0]       c;
  logic                    c_neg;
  logic signed [ACC_W-1:0] c_ext, c_abs;
  logic signed [31:0]      acc_w;
  logic                    dec_bit;
  logic                    dec_fire;

  always_comb begin
    c     = $signed({1'b0, sample}) - 8'sd64;
    c_neg = c[7];
    c_ext = ACC_W'(c);
    c_abs = c_neg ? -c_ext : c_ext;

    // sync wipes the window before this cycle's sample is folded in
    cnt_cur   = sync ? '0 : cnt_q;
    acc_cur   = sync ? '0 : acc_q;
    phase_cur = sync ? '0 : phase_q;
    prev_cur  = sync ? 1'b0 : prev_neg_q;
    mode_eff  = (cnt_cur == '0) ? sel : mode_q;

    state_d    = sync ? S_RUN : state_q;
    cnt_d      = cnt_cur;
    acc_d      = acc_cur;
    phase_d    = phase_cur;
    prev_neg_d = prev_cur;
    mode_d     = mode_q;
    bit_d      = bit_q;
    bv_d       = 1'b0;
    acc_nxt    = acc_cur;
    dec_fire   = 1'b0;

    if (sample_valid) begin
      state_d = S_RUN;
      if (cnt_cur == '0) mode_d = sel;
      case (mode_eff)
        M_ASK: acc_nxt = acc_cur + c_abs;
        M_FSK: begin
          if (c_neg != prev_cur) acc_nxt = acc_cur + ACC_W'(1);
          prev_neg_d = c_neg;
        end
        M_BPSK: begin
          acc_nxt = (phase_cur < PH_HALF) ? acc_cur + c_ext : acc_cur - c_ext;
          phase_d = (phase_cur == PH_LAST) ? '0 : phase_cur + PH_W'(1);
        end
        default: begin
          bit_d = ~c_neg;
          bv_d  = 1'b1;
        end
      endcase
      if (cnt_cur == CNT_LAST) begin
        cnt_d = '0;
        acc_d = '0;
        if (mode_eff != M_RAW) dec_fire = 1'b1;
      end else begin
        cnt_d = cnt_cur + CNT_W'(1);
        acc_d = acc_nxt;
      end
    end

    acc_w = 32'(acc_nxt);
    case (mode_eff)
      M_ASK:   dec_bit = acc_w > ASK_THR;
      M_FSK:   dec_bit = acc_w >= FSK_THR;
      default: dec_bit = acc_w < 0;
    endcase
    if (dec_fire) begin
      bit_d = dec_bit;
      bv_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      mode_q     <= M_ASK;
      prev_neg_q <= 1'b0;
      bit_q      <= 1'b0;
      bv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      prev_neg_q <= prev_neg_d;
      bit_q      <= bit_d;
      bv_q       <= bv_d;
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = bv_q;
  assign busy      = (state_q == S_RUN);

`ifdef DEMOD_MARGIN_CNT_EN
  logic [7:0] margin_q, margin_d;
  logic       near;

  // "Near" means the metric sits within an eighth of the decision threshold
  always_comb begin
    case (mode_eff)
      M_ASK:   near = (acc_w - ASK_THR < ASK_THR / 8) && (ASK_THR - acc_w < ASK_THR / 8);
      M_FSK:   near = (acc_w == FSK_THR - 1) || (acc_w == FSK_THR);
      default: near = (acc_w < 8 * SPB) && (acc_w > -8 * SPB);
    endcase
    margin_d = margin_q;
    if (dec_fire && near && margin_q != 8'hff) margin_d = margin_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) margin_q <= '0;
    else     margin_q <= margin_d;
  end

  assign margin_cnt = margin_q;
`endif

endmodule

// File: tb/tb_multimode_demod.sv
// Bench for multimode_demod: directed and random samples checked against a
// window-level model that recomputes each metric from the stored samples.
module tb_multimode_demod;
  localparam int SPB     = 16;
  localparam int CAR_PER = 8;
  localparam int ASK_THR = 256;
  localparam int FSK_THR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'b00;
  logic [6:0] sample = 7'd64;
  logic       sample_valid = 1'b0;
  logic       sync = 1'b0;
  logic       bit_out, bit_valid, busy;
`ifdef DEMOD_MARGIN_CNT_EN
  logic [7:0] margin_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  multimode_demod #(.SPB(SPB), .CAR_PER(CAR_PER), .ASK_THR(ASK_THR), .FSK_THR(FSK_THR)) dut (
    .clk(clk), .rst(rst), .sel(sel), .sample(sample), .sample_valid(sample_valid),
    .sync(sync), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy)
`ifdef DEMOD_MARGIN_CNT_EN
    , .margin_cnt(margin_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model state: the samples of the open window plus the cross-window context
  int   win_c[$];
  int   win_ph[$];
  int   win_x[$];
  int   win_mode;
  bit   m_prev_neg;
  int   m_phase;
  bit   m_busy;
  bit   m_bit;
  int   m_margin;
  logic [0:0] exp_q[$];

  task automatic model_reset();
    win_c.delete(); win_ph.delete(); win_x.delete();
    win_mode = 0; m_prev_neg = 0; m_phase = 0; m_busy = 0; m_bit = 0; m_margin = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input int s, input bit y, output bit ebv);
    int c, metric;
    bit near;
    ebv = 0;
    if (y) begin
      win_c.delete(); win_ph.delete(); win_x.delete();
      m_prev_neg = 0; m_phase = 0; m_busy = 1;
    end
    if (v) begin
      m_busy = 1;
      c = s - 64;
      if (win_c.size() == 0) win_mode = int'(sel);
      win_c.push_back(c);
      if (win_mode == 1) begin
        win_x.push_back(((c < 0) != m_prev_neg) ? 1 : 0);
        m_prev_neg = (c < 0);
      end
      if (win_mode == 2) begin
        win_ph.push_back(m_phase);
        m_phase = (m_phase + 1) % CAR_PER;
      end
      if (win_mode == 3) begin
        m_bit = (c >= 0); ebv = 1; exp_q.push_back(m_bit);
      end
      if (win_c.size() == SPB) begin
        if (win_mode != 3) begin
          metric = 0; near = 0;
          if (win_mode == 0) begin
            foreach (win_c[i]) metric += (win_c[i] < 0) ? -win_c[i] : win_c[i];
            m_bit = metric > ASK_THR;
            near = (metric - ASK_THR < ASK_THR / 8) && (ASK_THR - metric < ASK_THR / 8);
          end else if (win_mode == 1) begin
            foreach (win_x[i]) metric += win_x[i];
            m_bit = metric >= FSK_THR;
            near = (metric == FSK_THR - 1) || (metric == FSK_THR);
          end else begin
            foreach (win_c[i]) metric += (win_ph[i] < CAR_PER / 2) ? win_c[i] : -win_c[i];
            m_bit = metric < 0;
            near = (metric < 8 * SPB) && (metric > -8 * SPB);
          end
          ebv = 1; exp_q.push_back(m_bit);
          if (near && m_margin < 255) m_margin++;
        end
        win_c.delete(); win_ph.delete(); win_x.delete();
      end
    end
  endtask

  task automatic check_outputs(input bit ebv, input string tag);
    logic [0:0] e;
    n_cmp++;
    assert (bit_valid === ebv) else begin
      n_bad++; $error("FAIL %s bit_valid got=%0b exp=%0b t=%0t", tag, bit_valid, ebv, $time);
    end
    n_cmp++;
    assert (bit_out === m_bit) else begin
      n_bad++; $error("FAIL %s bit_out got=%0b exp=%0b t=%0t", tag, bit_out, m_bit, $time);
    end
    n_cmp++;
    assert (busy === m_busy) else begin
      n_bad++; $error("FAIL %s busy got=%0b exp=%0b t=%0t", tag, busy, m_busy, $time);
    end
    if (ebv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (bit_out === e) else begin
        n_bad++; $error("FAIL %s decided_bit got=%0b exp=%0b t=%0t", tag, bit_out, e, $time);
      end
    end
`ifdef DEMOD_MARGIN_CNT_EN
    n_cmp++;
    assert (int'(margin_cnt) === m_margin) else begin
      n_bad++; $error("FAIL %s margin_cnt got=%0d exp=%0d t=%0t", tag, margin_cnt, m_margin, $time);
    end
`endif
  endtask

  task automatic cycle(input bit v, input int s, input bit y, input string tag);
    bit ebv;
    @(negedge clk);
    sample_valid = v; sample = 7'(s); sync = y;
    model_step(v, s, y, ebv);
    @(posedge clk); #1;
    check_outputs(ebv, tag);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; sync = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    check_outputs(1'b0, "reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int bpsk_smp(input int k, input bit inv);
    bit hi;
    hi = ((k % CAR_PER) < CAR_PER / 2) ^ inv;
    return hi ? 100 : 28;
  endfunction

  initial begin
    model_reset();
    do_reset(2);
    repeat (3) cycle(0, 64, 0, "idle");
    cycle(1, 96, 0, "first_sample");

    sel = 2'b00;
    repeat (15) cycle(1, 96, 0, "ask_hi");
    repeat (16) cycle(1, 68, 0, "ask_lo");

    sel = 2'b01;
    for (int i = 0; i < 16; i++) cycle(1, (i % 2 == 0) ? 100 : 28, 0, "fsk_fast");
    for (int i = 0; i < 16; i++) cycle(1, (i < 8) ? 100 : 28, 0, "fsk_slow");

    sel = 2'b10;
    cycle(0, 64, 1, "bpsk_sync");
    for (int i = 0; i < 16; i++) cycle(1, bpsk_smp(i, 0), 0, "bpsk_inphase");
    for (int i = 0; i < 16; i++) cycle(1, bpsk_smp(i, 1), 0, "bpsk_inverted");
    for (int i = 0; i < 32; i++) begin
      cycle(1, bpsk_smp(i, i >= 16), 0, "bpsk_gap");
      repeat (3) cycle(0, $urandom_range(0, 127), 0, "bpsk_gap_idle");
    end

    sel = 2'b00;
    repeat (7) cycle(1, 96, 0, "pre_sync");
    cycle(0, 64, 1, "sync_mid");
    repeat (16) cycle(1, 96, 0, "post_sync");
    repeat (15) cycle(1, 96, 0, "pre_dec_sync");
    cycle(1, 96, 1, "sync_on_decision");
    repeat (15) cycle(1, 68, 0, "after_dec_sync");

    sel = 2'b11;
    cycle(0, 64, 1, "raw_sync");
    cycle(1, 63, 0, "raw_63");
    cycle(1, 64, 0, "raw_64");
    cycle(1, 0, 0, "raw_0");
    cycle(1, 127, 0, "raw_127");
    sel = 2'b00;
    repeat (12) cycle(1, 96, 0, "raw_tail");
    repeat (16) cycle(1, 96, 0, "ask_after_raw");

    repeat (15) cycle(1, 80, 0, "margin_ask");
    cycle(1, 84, 0, "margin_ask_last");

    repeat (5) cycle(1, 96, 0, "pre_rst");
    do_reset(1);
    repeat (3) cycle(0, 64, 0, "post_rst_idle");

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 127), $urandom_range(0, 39) == 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
